// File: rtl/wfetch_hidden.sv
// wfetch_hidden: weight-fetch sequencer for the hidden-layer weight memory.
// Walks one row (or all rows) of the flat weight memory, absorbs the
// memory's 1-cycle read latency and presents weights as a valid/ready
// stream. A 2-entry output buffer plus credit-based issue keeps full
// throughput under backpressure without dropping or duplicating weights.
//
// Optional feature: define WFETCH_STALL_CNT_EN to add the saturating
// stall_cnt output (cycles with out_valid=1 and out_ready=0).
module wfetch_hidden #(
    parameter int DATA_W   = 16,
    parameter int N_IN     = 8,
    parameter int N_HIDDEN = 4,
    localparam int ADDR_H_W = $clog2((N_HIDDEN > 2) ? N_HIDDEN : 2),
    localparam int ADDR_I_W = $clog2((N_IN > 2) ? N_IN : 2),
    localparam int RADDR_W  = $clog2((N_HIDDEN * N_IN > 2) ? N_HIDDEN * N_IN : 2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                start_all,
    input  logic [ADDR_H_W-1:0] start_h,
    output logic                busy,
    output logic                done,
    output logic [RADDR_W-1:0]  raddr,
    input  logic [DATA_W-1:0]   rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_H_W-1:0] out_h,
    output logic [ADDR_I_W-1:0] out_i,
    output logic                out_last
`ifdef WFETCH_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [ADDR_H_W-1:0] H_MAX   = ADDR_H_W'(N_HIDDEN - 1);
    localparam logic [ADDR_I_W-1:0] I_MAX   = ADDR_I_W'(N_IN - 1);
    localparam logic [RADDR_W-1:0]  ROW_LEN = RADDR_W'(N_IN);

    // Flat memory address of weight (h, i).
    function automatic logic [RADDR_W-1:0] addr_of(input logic [ADDR_H_W-1:0] h,
                                                    input logic [ADDR_I_W-1:0] i);
        return RADDR_W'(h) * ROW_LEN + RADDR_W'(i);
    endfunction

    state_t state, state_nxt;

    // Read pointer: (h_cur, i_cur) is the address currently held in raddr.
    logic [ADDR_H_W-1:0] h_cur, h_end, h_nxt, h_clamped, h_first;
    logic [ADDR_I_W-1:0] i_cur, i_nxt;
    logic                i_wrap, is_final;

    // One read in flight between raddr and the output buffer, with its tag.
    logic                inflight;
    logic [ADDR_H_W-1:0] tag_h;
    logic [ADDR_I_W-1:0] tag_i;
    logic                tag_last;

    // 2-entry output buffer.
    logic [DATA_W-1:0]   fifo_data [2];
    logic [ADDR_H_W-1:0] fifo_h    [2];
    logic [ADDR_I_W-1:0] fifo_i    [2];
    logic                fifo_last [2];
    logic                wr_ptr, rd_ptr;
    logic [1:0]          count;

    logic       pop, issue, drain_done, accept_start;
    logic [2:0] occ;

    assign busy         = (state != IDLE);
    assign out_valid    = (count != 2'd0);
    assign pop          = out_valid & out_ready;
    assign accept_start = (state == IDLE) & start;

    assign out_data = fifo_data[rd_ptr];
    assign out_h    = fifo_h[rd_ptr];
    assign out_i    = fifo_i[rd_ptr];
    assign out_last = out_valid & fifo_last[rd_ptr];

    assign h_clamped = (start_h > H_MAX) ? H_MAX : start_h;
    assign h_first   = start_all ? '0 : h_clamped;

    assign i_wrap   = (i_cur == I_MAX);
    assign i_nxt    = i_wrap ? '0 : i_cur + ADDR_I_W'(1);
    assign h_nxt    = i_wrap ? h_cur + ADDR_H_W'(1) : h_cur;
    assign is_final = i_wrap & (h_cur == h_end);

    // State register.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of the others; = here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic, credit check and issue decision.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        drain_done = 1'b0;
        // Buffered plus in-flight reads after this cycle's pop; never underflows
        // because pop implies count >= 1.
        occ        = 3'(count) + 3'(inflight) - 3'(pop);
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (is_final) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && count == 2'd1 && pop) begin
                    drain_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer, raddr and in-flight tag. raddr advances only on a
    // non-final issue, so it holds its value while nothing is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cur    <= '0;
            h_end    <= '0;
            i_cur    <= '0;
            raddr    <= '0;
            inflight <= 1'b0;
            tag_h    <= '0;
            tag_i    <= '0;
            tag_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept_start) begin
                h_cur <= h_first;
                h_end <= start_all ? H_MAX : h_clamped;
                i_cur <= '0;
                raddr <= addr_of(h_first, '0);
            end else if (issue) begin
                tag_h    <= h_cur;
                tag_i    <= i_cur;
                tag_last <= i_wrap;
                if (!is_final) begin
                    h_cur <= h_nxt;
                    i_cur <= i_nxt;
                    raddr <= addr_of(h_nxt, i_nxt);
                end
            end
        end
    end

    // Output buffer: capture returning read data, release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two buffer entries are reset because the head drives
            // the outputs directly and those must read zero out of reset.
            for (int k = 0; k < 2; k++) begin
                fifo_data[k] <= '0;
                fifo_h[k]    <= '0;
                fifo_i[k]    <= '0;
                fifo_last[k] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= rdata;
                fifo_h[wr_ptr]    <= tag_h;
                fifo_i[wr_ptr]    <= tag_i;
                fifo_last[wr_ptr] <= tag_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(inflight) - 2'(pop);
        end
    end

    // Completion pulse, one cycle after the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= drain_done;
    end

`ifdef WFETCH_STALL_CNT_EN
    // Saturating count of stalled output cycles, cleared on each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept_start) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wfetch_hidden.sv
// Directed testbench for wfetch_hidden with a 1-cycle-latency memory model
// preloaded with mem[h*8+i] = h*10+i+1.
module tb_wfetch_hidden;

    localparam int DATA_W   = 16;
    localparam int N_IN     = 8;
    localparam int N_HIDDEN = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_all;
    logic [1:0]  start_h;
    logic        busy, done;
    logic [4:0]  raddr;
    logic [15:0] rdata = '0;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [1:0]  out_h;
    logic [2:0]  out_i;
    logic        out_last;
`ifdef WFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    wfetch_hidden #(.DATA_W(DATA_W), .N_IN(N_IN), .N_HIDDEN(N_HIDDEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_all (start_all),
        .start_h   (start_h),
        .busy      (busy),
        .done      (done),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_h     (out_h),
        .out_i     (out_i),
        .out_last  (out_last)
`ifdef WFETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;

    int q_data[$];
    int q_h[$];
    int q_i[$];
    int q_last[$];
    int q_cyc[$];

    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: synchronous read, data valid the cycle after raddr.
    always @(posedge clk) begin
        rdata <= 16'((int'(raddr) / N_IN) * 10 + (int'(raddr) % N_IN) + 1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: head stability, read-ahead bound, handshake log, done pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid)
                check("read_ahead", 32'((int'(raddr) - (int'(out_h) * N_IN + int'(out_i))) <= 2), 32'd1);
            if (out_valid && out_ready) begin
                q_data.push_back(int'(out_data));
                q_h.push_back(int'(out_h));
                q_i.push_back(int'(out_i));
                q_last.push_back(int'(out_last));
                q_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // out_ready pattern per cycle offset t from start.
    function automatic logic rdy(input int mode, input int t);
        case (mode)
            1:       return (t % 4 == 0) || (t % 4 == 3);
            2:       return t >= 10;
            default: return 1'b1;
        endcase
    endfunction

    task automatic clear_log();
        q_data.delete(); q_h.delete(); q_i.delete(); q_last.delete(); q_cyc.delete();
    endtask

    // Issue a start and drive out_ready until done (bounded).
    // Mode 3 re-asserts start (all rows) in the middle of the fetch.
    task automatic run(input logic all, input logic [1:0] h, input int mode, input int limit);
        int t;
        int d0;
        d0 = done_cnt;
        clear_log();
        @(posedge clk); #1;
        start     = 1'b1;
        start_all = all;
        start_h   = h;
        start_cyc = cyc;
        out_ready = rdy(mode, 0);
        t = 0;
        while (done_cnt == d0 && t < limit) begin
            @(posedge clk); #1;
            t++;
            start     = (mode == 3) && (t == 4);
            start_all = (mode == 3) ? 1'b1 : all;
            out_ready = rdy(mode, t);
        end
        start = 1'b0;
        check("done_timeout", 32'(done_cnt != d0), 32'd1);
    endtask

    // Compare the handshake log against rows base_h..base_h+n_rows-1.
    task automatic check_rows(input int base_h, input int n_rows);
        int n;
        n = (q_data.size() < n_rows * N_IN) ? q_data.size() : n_rows * N_IN;
        check("n_weights", 32'(q_data.size()), 32'(n_rows * N_IN));
        for (int k = 0; k < n; k++) begin
            int h, i;
            h = base_h + k / N_IN;
            i = k % N_IN;
            check("data", 32'(q_data[k]), 32'(h * 10 + i + 1));
            check("out_h", 32'(q_h[k]), 32'(h));
            check("out_i", 32'(q_i[k]), 32'(i));
            check("out_last", 32'(q_last[k]), 32'(i == N_IN - 1));
        end
    endtask

    initial begin
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        start_all = 1'b0;
        start_h   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_h", 32'(out_h), 32'd0);
        check("rst_i", 32'(out_i), 32'd0);
`ifdef WFETCH_STALL_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single row 2, no backpressure: 8 back-to-back weights, done at +11.
        d0 = done_cnt;
        run(1'b0, 2'd2, 0, 40);
        check_rows(2, 1);
        check("row_first_hs", 32'((q_cyc.size() > 0) ? q_cyc[0] - start_cyc : -1), 32'd3);
        check("row_last_hs", 32'((q_cyc.size() == 8) ? q_cyc[7] - start_cyc : -1), 32'd10);
        check("row_done_lat", 32'(done_cyc - start_cyc), 32'd11);
        check("row_done_cnt", 32'(done_cnt - d0), 32'd1);

        // All rows: 32 weights, one per cycle, single done.
        d0 = done_cnt;
        run(1'b1, 2'd0, 0, 80);
        check_rows(0, 4);
        check("all_last_hs", 32'((q_cyc.size() == 32) ? q_cyc[31] - start_cyc : -1), 32'd34);
        check("all_done_lat", 32'(done_cyc - start_cyc), 32'd35);
        check("all_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Backpressure 1,0,0,1 on row 1: three 2-cycle stall windows.
        d0 = done_cnt;
        run(1'b0, 2'd1, 1, 60);
        check_rows(1, 1);
        check("bp_done_lat", 32'(done_cyc - start_cyc), 32'd17);
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef WFETCH_STALL_CNT_EN
        check("bp_stall_cnt", 32'(stall_cnt), 32'd6);
`endif

        // out_ready low for 10 cycles after start: head holds weight 1.
        d0 = done_cnt;
        fork
            run(1'b0, 2'd0, 2, 60);
            begin
                repeat (9) @(negedge clk);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_head", 32'(out_data), 32'd1);
                check("stall_head_i", 32'(out_i), 32'd0);
            end
        join
        check_rows(0, 1);
        check("stall_done_lat", 32'(done_cyc - start_cyc), 32'd18);
        check("stall_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef WFETCH_STALL_CNT_EN
        check("stall_cnt_7", 32'(stall_cnt), 32'd7);
`endif

        // Start re-asserted during fetch of row 0 is ignored.
        d0 = done_cnt;
        run(1'b0, 2'd0, 3, 40);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_rows(0, 1);
        check("retrig_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("retrig_idle", 32'(busy), 32'd0);

        // Reset mid-fetch of row 3 after three handshakes.
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; start_all = 1'b0; start_h = 2'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 20 && q_data.size() < 3; t++) begin
            @(posedge clk); #1;
        end
        check("abort_hs", 32'(q_data.size()), 32'd3);
        check("abort_data", 32'((q_data.size() == 3) ? q_data[2] : -1), 32'd33);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_last", 32'(out_last), 32'd0);
        check("abort_raddr", 32'(raddr), 32'd0);
        check("abort_data0", 32'(out_data), 32'd0);
        check("abort_h", 32'(out_h), 32'd0);
        check("abort_i", 32'(out_i), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        d0 = done_cnt;
        run(1'b0, 2'd0, 0, 40);
        check_rows(0, 1);
        check("post_rst_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("post_rst_done_lat", 32'(done_cyc - start_cyc), 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wfetch_hidden.md
# wfetch_hidden

Weight-fetch sequencer on the read side of `wmem_hidden`. On a start command it walks one hidden-neuron row, or all rows, of the flat weight memory. It drives `raddr`, absorbs the memory's 1-cycle read latency, and presents weights as a valid/ready stream to the bit-serial neuron datapath. A 2-entry output buffer with credit-based read issue gives full throughput under backpressure with no dropped or duplicated weights.

## Interface
- `DATA_W`, 16: weight width, signed two's complement.
- `N_IN`, 8: weights per hidden neuron (row length).
- `N_HIDDEN`, 4: number of rows.
- Derived: `ADDR_H_W = $clog2(max(N_HIDDEN,2))`, `ADDR_I_W = $clog2(max(N_IN,2))`, `RADDR_W = $clog2(max(N_HIDDEN*N_IN,2))`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `start_all` in 1: with `start`, 1 = fetch rows 0..N_HIDDEN-1; 0 = fetch row `start_h` only.
- `start_h` in ADDR_H_W: row for a single-row fetch.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: 1-cycle pulse after the final output handshake.
- `raddr` out RADDR_W: registered memory read address.
- `rdata` in DATA_W: memory read data, valid 1 cycle after `raddr`.
- `out_valid` out 1: output stream valid.
- `out_ready` in 1: output stream ready.
- `out_data` out DATA_W: weight.
- `out_h` out ADDR_H_W: row index of `out_data`.
- `out_i` out ADDR_I_W: column index of `out_data`.
- `out_last` out 1: marks the final weight of each row (i = N_IN-1).
- `stall_cnt` out 16: present only with `WFETCH_STALL_CNT_EN`.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE → FETCH when `start`=1. Latch the row range: h_cur = `start_all` ? 0 : `start_h`; h_end = `start_all` ? N_HIDDEN-1 : `start_h`. Set i_cur = 0.
- Issue address = h_cur*N_IN + i_cur.
- Issue condition: state is FETCH and (fifo_count + inflight − pop) < 2, where pop = `out_valid & out_ready`.
- On issue:
  - Register the address into `raddr`.
  - Set inflight for the next cycle.
  - Tag the read with (h, i, last).
  - Advance i_cur; when i_cur wraps from N_IN-1 to 0, increment h_cur.
- FETCH → DRAIN when the issued address is (h_end, N_IN-1).
- Capture: the cycle after an issue, write `rdata` and its tag into the 2-entry FIFO.
- Output fields come from the FIFO head. `out_valid` = fifo_count != 0.
- DRAIN → IDLE when inflight = 0, fifo_count = 1 and pop = 1. `done` is high in the following cycle.
- `start` while busy is ignored; no queuing.
- `out_valid` must not drop, and the head must not change, while `out_ready`=0.
- A `start_h` ≥ N_HIDDEN is clamped to N_HIDDEN-1.
- `rst_n` low at any time, including mid-fetch, aborts the operation with no drain.

## Timing
- Reset values:
  - `busy`, `done`, `out_valid`, `out_last` = 0.
  - `raddr`, `out_data`, `out_h`, `out_i` = 0.
  - FIFO empty, inflight = 0, `stall_cnt` = 0, state = IDLE.
- `start` sampled in cycle 0 → `raddr` = first address in cycle 1 → `rdata` captured at the end of cycle 2 → `out_valid` = 1 in cycle 3.
- With `out_ready` held at 1, one weight per cycle. A row takes N_IN+3 cycles from `start` to `done`.
- Backpressure:
  - Issue stops once fifo_count + inflight reaches 2.
  - Issue resumes in the same cycle `out_ready` returns, because pop is part of the issue condition.
- `raddr` holds its last value while no read is issued.

## Configuration
- `WFETCH_STALL_CNT_EN` defined:
  - Adds the `stall_cnt` port.
  - Increments in every cycle with `out_valid`=1 and `out_ready`=0.
  - Saturates at 16'hFFFF.
  - Clears on reset and on each accepted `start`.
- Not defined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
All scenarios use a memory model preloaded with mem[h*N_IN+i] = h*10+i+1 and a 1-cycle read latency.
- Single row, no backpressure: `start`, `start_all`=0, `start_h`=2, `out_ready`=1 → data 21..28 on 8 consecutive cycles. `out_i` = 0..7, `out_h` = 2, `out_last` only on 28. `done` 11 cycles after `start`.
- All rows: `start_all`=1, `out_ready`=1 → 32 weights 1..8, 11..18, 21..28, 31..38. `out_last` 4 times; one `done`.
- Backpressure: `out_ready` toggling 1,0,0,1 on row 1 → output sequence exactly 11..18 with no gaps in the data. Head stable during stalls. `raddr` issues no more than 2 ahead of the consumer. `stall_cnt` = 2×(number of stall windows) when the macro is enabled.
- `out_ready`=0 for 10 cycles after `start` → `out_valid` stays 1 with data 1. Exactly 2 reads are outstanding or buffered. Releasing `out_ready` yields 1..8 in order.
- `start` asserted again during FETCH of row 0 → ignored; exactly 8 weights and one `done`.
- `rst_n` pulsed low after 3 handshakes of row 3 → all outputs return to reset values immediately. A fresh `start` on row 0 yields 1..8 correctly.
